// File: rtl/param_updown_counter.sv
// param_updown_counter: WIDTH-bit modulo-MODULUS up/down counter with enable, sync load and wrap pulse
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   enable     : count enable
//   up_down    : 1 = count up, 0 = count down
//   load       : synchronous parallel load (wins over enable, never wraps)
//   load_value : binary value to load; values >= MODULUS load 0
//   y          : registered count, binary or Gray when PARAM_COUNTER_GRAY_OUT_EN is defined
//   wrap       : registered pulse, high while y shows the wrapped value
module param_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] y,
    output logic             wrap
);
    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH/MODULUS");
    end
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    logic [WIDTH-1:0] count, count_nxt;
    logic wrap_nxt;
    logic out_of_range;
    assign out_of_range = 32'(count) >= MODULUS;
    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (32'(load_value) < MODULUS) ? load_value : '0;
        end else if (enable) begin
            // unreachable counts recover to 0 without signalling a wrap
            if (out_of_range) begin
                count_nxt = '0;
            end else if (up_down) begin
                wrap_nxt  = count == LAST;
                count_nxt = wrap_nxt ? '0 : count + 1'b1;
            end else begin
                wrap_nxt  = count == '0;
                count_nxt = wrap_nxt ? LAST : count - 1'b1;
            end
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            y     <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
`ifdef PARAM_COUNTER_GRAY_OUT_EN
            y     <= count_nxt ^ (count_nxt >> 1);
`else
            y     <= count_nxt;
`endif
        end
    end
endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised successor to the team's fixed 3-bit free-running binary counter FSM.
- Generalised to WIDTH bits with a programmable modulus, plus up/down counting, count enable, synchronous parallel load and a registered wrap pulse.
- Used as a general counter / sequence generator and as a timebase for display and lab sequencing blocks.

Parameters:
- WIDTH, 4, counter and output width in bits; legal range 2..16.
- MODULUS, 16, number of count states, so the count runs 0..MODULUS-1; legal range 2..2^WIDTH. Illegal values must be rejected at elaboration.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count enable; the counter advances only when high.
- up_down  input  1  direction select: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- load_value  input  WIDTH  value loaded when load=1.
- y  output  WIDTH  registered count value, binary, or Gray-coded with the optional feature.
- wrap  output  1  registered one-cycle pulse marking a modulus wrap.

Behaviour:
- Clock and reset: one clock, posedge clock. Reset is asynchronous and active-low.
- While reset=0: internal count=0, y=0, wrap=0, independent of clock. Deassertion mid-count restarts from 0; no partial state is retained.
- Per-edge priority, highest first:
  1. load=1: count <= load_value if load_value < MODULUS, otherwise count <= 0. wrap <= 0. Load is honoured whether enable is 0 or 1.
  2. enable=1, up_down=1: if count == MODULUS-1 then count <= 0 and wrap <= 1; otherwise count <= count+1 and wrap <= 0.
  3. enable=1, up_down=0: if count == 0 then count <= MODULUS-1 and wrap <= 1; otherwise count <= count-1 and wrap <= 0.
  4. enable=0: count holds, wrap <= 0.
- Latency: y reflects the new count one clock after the controlling inputs are sampled. wrap is high during exactly the cycle in which y shows the wrapped value (0 going up, MODULUS-1 going down).
- Simultaneous load and enable: load wins and no wrap is generated, even if load_value equals a wrap target.
- A direction change takes effect on the next enabled edge. There is no hysteresis and no lost count.
- Arithmetic is done in WIDTH bits. When MODULUS = 2^WIDTH the natural overflow and underflow coincide with the wrap rule.
- Counting is a controlling state register (count) plus next-state logic, following the team's FSM style. The next-state logic is fully specified for every count value, including unreachable ones: any count >= MODULUS steps to 0 on the next enabled edge. No latches.
- The internal count is always binary. Only the output encoding changes with the optional feature.

Optional Feature:
- Macro: PARAM_COUNTER_GRAY_OUT_EN.
- Defined: y = count ^ (count >> 1), i.e. Gray-coded and registered, with the same timing as binary mode. Successive y values differ by one bit, including at the wrap, when MODULUS is a power of two. For other moduli the wrap transition may change more than one bit; this is legal and documented.
- Undefined: y = count in plain binary.
- wrap, load semantics and load_value encoding (always binary) are identical in both builds.

Test Plan:
- Reset/count: WIDTH=4, MODULUS=16. Hold reset=0 for 2 cycles, then release with enable=1, up_down=1 → y = 0,1,…,15,0. wrap=1 only in the cycle y returns to 0.
- Modulus/down: MODULUS=10, load 3, then enable=1, up_down=0 → y = 3,2,1,0,9,8. wrap=1 only in the cycle y=9.
- Load priority/range: count=5. Assert load=1, enable=1, load_value=12 with MODULUS=10 → y=0, wrap=0. Repeat with load_value=7 → y=7. With enable=0 and load=0 → y holds 7 for 4 cycles.
- Async reset: assert reset=0 between clock edges while y=6 → y=0 and wrap=0 immediately. After release with enable=1 → y=1 on the first edge.
- Direction flip: y=4 with up, toggle up_down every edge → y = 5,4,5,4. wrap never asserts.
- Gray build (PARAM_COUNTER_GRAY_OUT_EN, WIDTH=3, MODULUS=8): count up → y = 000,001,011,010,110,111,101,100,000. Exactly one bit changes per step, and wrap is aligned with y=000.
